// File: rtl/key_event_decoder.sv
// Turns a debounced active-low key level into press/release/short/long/repeat pulses and a held level.
// Define KEY_EVENT_REPEAT_EN to enable auto-repeat while a long press is held.
module key_event_decoder #(
    parameter int unsigned LONG_CNT   = 25000000,
    parameter int unsigned REPEAT_CNT = 5000000,
    parameter int unsigned CNT_W      = 25
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic key_held
);

    typedef enum logic [1:0] {ARM, IDLE, PRESSED, LONG} state_t;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CNT - 1);
`ifdef KEY_EVENT_REPEAT_EN
    localparam logic REPEAT_ON = 1'b1;
`else
    localparam logic REPEAT_ON = 1'b0;
`endif

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_d, release_d, short_d, long_d, repeat_d, held_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ARM;
            cnt_q         <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            short_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            key_held      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
            short_pulse   <= short_d;
            long_pulse    <= long_d;
            repeat_pulse  <= repeat_d;
            key_held      <= held_d;
        end
    end

    // A release always wins over a terminal count sampled on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ARM: begin
                if (key_level) begin
                    state_d = IDLE;
                end
                cnt_d = '0;
            end
            IDLE: begin
                cnt_d = '0;
                if (!key_level) begin
                    state_d = PRESSED;
                    press_d = 1'b1;
                end
            end
            PRESSED: begin
                if (key_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    short_d   = 1'b1;
                    cnt_d     = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            LONG: begin
                if (key_level) begin
                    state_d   = IDLE;
                    release_d = 1'b1;
                    cnt_d     = '0;
                end else if (!REPEAT_ON) begin
                    cnt_d = '0;
                end else if (cnt_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARM;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == PRESSED) || (state_d == LONG);
    end

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder using an event-timing reference model.
module tb_key_event_decoder;

    localparam int LONG_N = 8;
    localparam int REP_N  = 4;
`ifdef KEY_EVENT_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic key_level = 1'b1;
    logic press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held;
    logic [5:0] outs;
    logic [5:0] exp_outs;

    bit armed;
    bit held;
    int age;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    key_event_decoder #(
        .LONG_CNT(LONG_N),
        .REPEAT_CNT(REP_N),
        .CNT_W(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .key_level(key_level),
        .press_pulse(press_pulse),
        .release_pulse(release_pulse),
        .short_pulse(short_pulse),
        .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse),
        .key_held(key_held)
    );

    assign outs = {press_pulse, release_pulse, short_pulse, long_pulse, repeat_pulse, key_held};

    // Reference: age counts edges since the press; events follow from age alone.
    task automatic model_edge(input logic k);
        logic p, r, s, l, rp;
        p = 0; r = 0; s = 0; l = 0; rp = 0;
        if (!armed) begin
            if (k) armed = 1;
        end else if (!held) begin
            if (!k) begin
                held = 1;
                age = 0;
                p = 1;
            end
        end else begin
            age++;
            if (k) begin
                r = 1;
                s = (age <= LONG_N);
                held = 0;
            end else begin
                l = (age == LONG_N);
                rp = REP_EN && (age > LONG_N) && ((age - LONG_N) % REP_N == 0);
            end
        end
        exp_outs = {p, r, s, l, rp, held};
    endtask

    task automatic tick(input logic k);
        @(negedge clk);
        key_level = k;
        @(posedge clk);
        model_edge(k);
        #1;
    endtask

    task automatic do_reset(input logic k);
        key_level = k;
        rst_n = 1'b0;
        armed = 0;
        held = 0;
        age = 0;
        exp_outs = '0;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_init got %b want %b", outs, 6'b0);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold got %b want %b", outs, 6'b0);
        end
        release_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL reset_arm cyc %0d got %b want %b", i, outs, exp_outs);
            end
        end
    endtask

    task automatic test_key_through_reset();
        logic [0:13] seq;
        seq = 14'b0000000000_1110;
        do_reset(1'b0);
        repeat (2) @(posedge clk);
        release_reset();
        for (int i = 0; i < 14; i++) begin
            tick(seq[i]);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL key_thru_reset cyc %0d got %b want %b", i, outs, exp_outs);
            end
        end
        checks++;
        if (press_pulse !== 1'b1) begin
            errors++;
            $display("FAIL key_thru_reset_press got %b want 1", press_pulse);
        end
        tick(1'b1);
        tick(1'b1);
    endtask

    task automatic test_short_press();
        int long_seen;
        long_seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick(i < 5 ? 1'b0 : 1'b1);
            long_seen += int'(long_pulse);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL short_press cyc %0d got %b want %b", i, outs, exp_outs);
            end
        end
        checks++;
        if (long_seen != 0) begin
            errors++;
            $display("FAIL short_press_nolong got %0d want 0", long_seen);
        end
    endtask

    task automatic test_long_boundary(input int hold);
        for (int i = 0; i < hold + 3; i++) begin
            tick(i < hold ? 1'b0 : 1'b1);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL long_boundary_%0d cyc %0d got %b want %b", hold, i, outs, exp_outs);
            end
        end
    endtask

    task automatic test_long_repeat(input int hold);
        int rep_seen, rep_want;
        rep_seen = 0;
        rep_want = REP_EN ? (hold - 1 - LONG_N) / REP_N : 0;
        for (int i = 0; i < hold + 3; i++) begin
            tick(i < hold ? 1'b0 : 1'b1);
            rep_seen += int'(repeat_pulse);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL long_repeat_%0d cyc %0d got %b want %b", hold, i, outs, exp_outs);
            end
        end
        checks++;
        if (rep_seen != rep_want) begin
            errors++;
            $display("FAIL repeat_count_%0d got %0d want %0d", hold, rep_seen, rep_want);
        end
    endtask

    task automatic test_reset_in_long();
        for (int i = 0; i < 11; i++) tick(1'b0);
        #2;
        do_reset(1'b0);
        checks++;
        if (outs !== 6'b0) begin
            errors++;
            $display("FAIL reset_in_long got %b want %b", outs, 6'b0);
        end
        release_reset();
        for (int i = 0; i < 10; i++) begin
            tick(i == 6 ? 1'b1 : 1'b0);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL after_reset cyc %0d got %b want %b", i, outs, exp_outs);
            end
        end
        tick(1'b1);
        tick(1'b1);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            tick(i[0]);
            checks++;
            if (outs !== exp_outs) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %b want %b", i, outs, exp_outs);
            end
        end
    endtask

    task automatic test_random();
        logic k;
        int run;
        for (int n = 0; n < 150; n++) begin
            k = logic'($urandom_range(0, 1));
            run = $urandom_range(1, 30);
            for (int i = 0; i < run; i++) begin
                tick(k);
                checks++;
                if (outs !== exp_outs) begin
                    errors++;
                    $display("FAIL random run %0d cyc %0d got %b want %b", n, i, outs, exp_outs);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_key_through_reset();
        test_short_press();
        test_long_boundary(LONG_N);
        test_long_boundary(LONG_N + 1);
        test_long_repeat(20);
        test_long_repeat(40);
        test_reset_in_long();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
